// File: rtl/memorybank_pkg.sv
// Shared constants and types for the memory bank node.
// Optional feature macro: MEMBANK_VALID_EN (per-entry written-since-reset flag).
package memorybank_pkg;

   localparam int WORD_WIDTH  = 16;
   localparam int MEM_DEPTH   = 64;
   localparam int INDEX_WIDTH = 6;

   typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : memorybank_pkg

// File: rtl/memorybank_word.sv
// One storage entry of the memory bank: a WORD_WIDTH register with
// synchronous reset and write enable.
// Optional feature macro: MEMBANK_VALID_EN adds a sticky valid flag that is
// set by any write and cleared by reset.
module memorybank_word
   import memorybank_pkg::*;
#(
   parameter int WORD_WIDTH = memorybank_pkg::WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [WORD_WIDTH-1:0] data_out
`ifdef MEMBANK_VALID_EN
   ,
   output logic                  valid
`endif
);

   logic [WORD_WIDTH-1:0] word_q;

   // Entry register: reset wins over a same-cycle write, otherwise load on wr_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
      end else if (wr_en) begin
         word_q <= data_in;
      end
   end

   assign data_out = word_q;

`ifdef MEMBANK_VALID_EN
   logic valid_q;

   // Valid flag: cleared by reset, set once the entry has been written.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else if (wr_en) begin
         valid_q <= 1'b1;
      end
   end

   assign valid = valid_q;
`else
   // Without the valid feature an entry carries only its data word.
`endif

endmodule : memorybank_word

// File: rtl/memorybank_node.sv
// Flip-flop based memory bank: MEM_DEPTH words, one shared index for the
// synchronous write port and the combinational read port.
// Reads show the registered contents only (no write-through), so a write to
// the addressed entry becomes visible after the clock edge.
// Optional feature macro: MEMBANK_VALID_EN adds the data_valid output, a
// combinational read of the per-entry written-since-reset flag.
module memorybank_node
   import memorybank_pkg::*;
#(
   parameter int WORD_WIDTH  = memorybank_pkg::WORD_WIDTH,
   parameter int MEM_DEPTH   = memorybank_pkg::MEM_DEPTH,
   parameter int INDEX_WIDTH = memorybank_pkg::INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic [WORD_WIDTH-1:0]  data_in,
   output logic [WORD_WIDTH-1:0]  data_out
`ifdef MEMBANK_VALID_EN
   ,
   output logic                   data_valid
`endif
);

   logic [WORD_WIDTH-1:0] entry_data [MEM_DEPTH];
   logic [MEM_DEPTH-1:0]  entry_sel;

`ifdef MEMBANK_VALID_EN
   logic [MEM_DEPTH-1:0]  entry_valid;
`endif

   // Entry array: each word is enabled only when the shared index decodes to it.
   // Indices at or beyond MEM_DEPTH decode to no entry, so such writes are dropped.
   for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_entry
      assign entry_sel[i] = (index == INDEX_WIDTH'(i));

      memorybank_word #(
         .WORD_WIDTH (WORD_WIDTH)
      ) u_word (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en && entry_sel[i]),
         .data_in  (data_in),
         .data_out (entry_data[i])
`ifdef MEMBANK_VALID_EN
         ,
         .valid    (entry_valid[i])
`endif
      );
   end

   // Read mux: one-hot select of the addressed entry; an unmatched index reads 0.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         if (entry_sel[i]) begin
            data_out = entry_data[i];
         end
      end
   end

`ifdef MEMBANK_VALID_EN
   // Valid read: same selection as the data path, unmatched index reads not-valid.
   always_comb begin
      data_valid = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         if (entry_sel[i]) begin
            data_valid = entry_valid[i];
         end
      end
   end
`else
   // Without the valid feature only the data word is read out.
`endif

endmodule : memorybank_node

// File: tb/tb_memorybank_node.sv
// Directed self-checking bench for memorybank_node.
// Build with MEMBANK_VALID_EN defined to also check the data_valid output.
module tb_memorybank_node;
   import memorybank_pkg::*;

   logic                   clk;
   logic                   rst;
   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] index;
   word_t                  data_in;
   word_t                  data_out;
`ifdef MEMBANK_VALID_EN
   logic                   data_valid;
`endif

   int total;
   int bad;

   memorybank_node #(
      .WORD_WIDTH  (WORD_WIDTH),
      .MEM_DEPTH   (MEM_DEPTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .index      (index),
      .data_in    (data_in),
      .data_out   (data_out)
`ifdef MEMBANK_VALID_EN
      ,
      .data_valid (data_valid)
`endif
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Point the read port at an entry and compare its data word.
   task automatic check_data(input string name, input int idx, input word_t expected);
      index = INDEX_WIDTH'(idx);
      #1;
      total++;
      if (data_out !== expected) begin
         bad++;
         $display("[TB] FAIL %s idx=%0d: got %h expected %h", name, idx, data_out, expected);
      end
   endtask

`ifdef MEMBANK_VALID_EN
   task automatic check_valid(input string name, input int idx, input logic expected);
      index = INDEX_WIDTH'(idx);
      #1;
      total++;
      if (data_valid !== expected) begin
         bad++;
         $display("[TB] FAIL %s idx=%0d: valid got %b expected %b", name, idx, data_valid, expected);
      end
   endtask
`endif

   task automatic write_word(input int idx, input word_t value);
      index   = INDEX_WIDTH'(idx);
      data_in = value;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   // One reset cycle, then every entry must read zero.
   task automatic test_reset();
      rst     = 1'b1;
      wr_en   = 1'b0;
      index   = '0;
      data_in = '0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         check_data("reset_sweep", i, 16'h0000);
`ifdef MEMBANK_VALID_EN
         check_valid("reset_valid", i, 1'b0);
`endif
      end
   endtask

   // First write lands in entry 0 only, visible right after the edge.
   task automatic test_first_write();
      index   = 6'd0;
      data_in = 16'h0003;
      wr_en   = 1'b1;
      #1;
      check_data("first_write_pre_edge", 0, 16'h0000);
      tick();
      wr_en = 1'b0;
      check_data("first_write_post_edge", 0, 16'h0003);
      check_data("first_write_neighbour", 1, 16'h0000);
`ifdef MEMBANK_VALID_EN
      check_valid("first_write_valid", 0, 1'b1);
      check_valid("first_write_neighbour_valid", 1, 1'b0);
`endif
   endtask

   // Held-off write, then a real write; old value shown until the edge.
   task automatic test_hold_then_write();
      index   = 6'd1;
      data_in = 16'h000F;
      wr_en   = 1'b0;
      tick();
      tick();
      check_data("hold_no_write", 1, 16'h0000);
      wr_en = 1'b1;
      check_data("hold_old_before_edge", 1, 16'h0000);
      tick();
      wr_en = 1'b0;
      check_data("hold_new_after_edge", 1, 16'h000F);
      check_data("hold_entry0_kept", 0, 16'h0003);
   endtask

   // Reset together with a write drops the write and clears everything.
   task automatic test_reset_priority();
      write_word(9, 16'h5678);
      check_data("pre_reset_entry9", 9, 16'h5678);
      index   = 6'd5;
      data_in = 16'hABCD;
      wr_en   = 1'b1;
      rst     = 1'b1;
      tick();
      rst   = 1'b0;
      wr_en = 1'b0;
      check_data("reset_prio_entry5", 5, 16'h0000);
      for (int i = 0; i < MEM_DEPTH; i++) begin
         check_data("reset_prio_sweep", i, 16'h0000);
`ifdef MEMBANK_VALID_EN
         check_valid("reset_prio_valid", i, 1'b0);
`endif
      end
   endtask

   // Top and bottom entries are independent.
   task automatic test_boundary();
      write_word(63, 16'hFFFF);
      write_word(0, 16'h0001);
      check_data("boundary_top", 63, 16'hFFFF);
      check_data("boundary_bottom", 0, 16'h0001);
      check_data("boundary_below_top", 62, 16'h0000);
      check_data("boundary_above_bottom", 1, 16'h0000);
      check_data("boundary_top_again", 63, 16'hFFFF);
   endtask

   // Consecutive-cycle writes to one entry, then hold.
   task automatic test_back_to_back();
      index   = 6'd7;
      data_in = 16'h1111;
      wr_en   = 1'b1;
      tick();
      check_data("b2b_first", 7, 16'h1111);
      data_in = 16'h2222;
      tick();
      check_data("b2b_second", 7, 16'h2222);
      wr_en   = 1'b0;
      data_in = 16'h3333;
      tick();
      check_data("b2b_hold", 7, 16'h2222);
      check_data("b2b_neighbour_low", 6, 16'h0000);
      check_data("b2b_neighbour_high", 8, 16'h0000);
      check_data("b2b_top_kept", 63, 16'hFFFF);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst     = 1'b0;
      wr_en   = 1'b0;
      index   = '0;
      data_in = '0;
      @(negedge clk);
      test_reset();
      test_first_write();
      test_hold_then_write();
      test_reset_priority();
      test_boundary();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_memorybank_node
